// File: rtl/branch_resolve_predict.sv
// rtl/branch_resolve_predict.sv - RV32IC branch resolution with a 2-bit saturating-counter predictor
module branch_resolve_predict #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] INIT_STATE  = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic             res_is_branch,
    input  logic [2:0]       res_funct3,
    input  logic             res_compressed,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [XLEN-1:0]  res_rs1,
    input  logic [XLEN-1:0]  res_rs2,
    input  logic [XLEN-1:0]  res_target,
    input  logic             res_pred_taken,
    output logic             br_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal_funct3,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int IW = $clog2(BHT_ENTRIES);

    logic [1:0]    bht [BHT_ENTRIES];
    logic [IW-1:0] pred_idx;
    logic [IW-1:0] res_idx;
    logic [XLEN:0] diff;
    logic          flag_c, flag_z, flag_s, flag_v;
    logic          outcome;
    logic          f3_illegal;
    logic          legal_ev;
    logic          illegal_ev;
    logic          mispredict;
    logic          unused_bits;

    assign pred_idx = pred_pc[IW:1];
    assign res_idx  = res_pc[IW:1];

    // Table is read before any same-cycle update lands, so there is no bypass.
    assign pred_taken = bht[pred_idx][1];

    assign diff   = {1'b0, res_rs1} + {1'b0, ~res_rs2} + {{XLEN{1'b0}}, 1'b1};
    assign flag_c = diff[XLEN];
    assign flag_z = (res_rs1 == res_rs2);
    assign flag_s = diff[XLEN-1];
    assign flag_v = (res_rs1[XLEN-1] != res_rs2[XLEN-1]) && (diff[XLEN-1] != res_rs1[XLEN-1]);

    assign unused_bits = ^{pred_pc[XLEN-1:IW+1], pred_pc[0], res_pc[0], diff[XLEN-2:0]};

    always_comb begin
        outcome = 1'b0;
        case (res_funct3)
            3'b000:  outcome = flag_z;
            3'b001:  outcome = !flag_z;
            3'b100:  outcome = (flag_s != flag_v);
            3'b101:  outcome = (flag_s == flag_v);
            3'b110:  outcome = !flag_c;
            3'b111:  outcome = flag_c;
            default: outcome = 1'b0;
        endcase
    end

    assign f3_illegal = (res_funct3[2:1] == 2'b01);
    assign legal_ev   = res_valid && res_is_branch && !f3_illegal;
    assign illegal_ev = res_valid && res_is_branch && f3_illegal;
    assign mispredict = (outcome != res_pred_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= INIT_STATE;
            end
            br_taken       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            illegal_funct3 <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            br_taken       <= 1'b0;
            redirect_valid <= 1'b0;
            illegal_funct3 <= illegal_ev;
            if (legal_ev) begin
                br_taken       <= outcome;
                redirect_valid <= mispredict;
                redirect_pc    <= outcome ? res_target
                                          : res_pc + (res_compressed ? XLEN'(2) : XLEN'(4));
                if (!(&branch_cnt)) begin
                    branch_cnt <= branch_cnt + 1'b1;
                end
                if (mispredict && !(&mispredict_cnt)) begin
                    mispredict_cnt <= mispredict_cnt + 1'b1;
                end
                if (outcome) begin
                    if (bht[res_idx] != 2'b11) bht[res_idx] <= bht[res_idx] + 2'b01;
                end else begin
                    if (bht[res_idx] != 2'b00) bht[res_idx] <= bht[res_idx] - 2'b01;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb/tb_branch_resolve_predict.sv - directed self-checking bench for branch_resolve_predict
module tb_branch_resolve_predict;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid, res_is_branch, res_compressed, res_pred_taken;
    logic [2:0]  res_funct3;
    logic [31:0] res_pc, res_rs1, res_rs2, res_target;
    logic        br_taken, redirect_valid, illegal_funct3;
    logic [31:0] redirect_pc, branch_cnt, mispredict_cnt;

    int errors = 0;
    int checks = 0;

    branch_resolve_predict dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_funct3(res_funct3),
        .res_compressed(res_compressed), .res_pc(res_pc), .res_rs1(res_rs1),
        .res_rs2(res_rs2), .res_target(res_target), .res_pred_taken(res_pred_taken),
        .br_taken(br_taken), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .illegal_funct3(illegal_funct3), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic comp, input logic pred);
        res_valid = 1'b1; res_is_branch = 1'b1; res_funct3 = f3;
        res_rs1 = a; res_rs2 = b; res_pc = pc; res_target = tgt;
        res_compressed = comp; res_pred_taken = pred;
        @(posedge clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic tk, input logic rv,
                              input logic [31:0] rpc, input logic [31:0] bc, input logic [31:0] mc);
        check({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, tk});
        check({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
        check({tag, ".redirect_pc"}, redirect_pc, rpc);
        check({tag, ".branch_cnt"}, branch_cnt, bc);
        check({tag, ".mispredict_cnt"}, mispredict_cnt, mc);
    endtask

    task automatic expect_pred(input string tag, input logic [31:0] pc, input logic exp);
        pred_pc = pc; #1;
        check(tag, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1; pred_pc = '0;
        res_valid = 1'b0; res_is_branch = 1'b0; res_funct3 = '0; res_compressed = 1'b0;
        res_pc = '0; res_rs1 = '0; res_rs2 = '0; res_target = '0; res_pred_taken = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int p = 0; p < 128; p += 2) begin
            expect_pred("reset_pred", p, 1'b0);
        end
        expect_res("reset", 1'b0, 1'b0, 32'h0, 32'd0, 32'd0);
        check("reset.illegal", {31'd0, illegal_funct3}, 32'd0);

        resolve(3'b000, 32'd5, 32'd5, 32'h40, 32'h100, 1'b0, 1'b0);
        expect_res("beq", 1'b1, 1'b1, 32'h100, 32'd1, 32'd1);
        expect_pred("beq_pred", 32'h40, 1'b1);

        resolve(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b0, 1'b1);
        expect_res("blt", 1'b1, 1'b0, 32'h300, 32'd2, 32'd1);
        resolve(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b0, 1'b1);
        expect_res("bltu", 1'b0, 1'b1, 32'h204, 32'd3, 32'd2);
        resolve(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h200, 32'h300, 1'b0, 1'b0);
        expect_res("bge", 1'b0, 1'b0, 32'h204, 32'd4, 32'd2);

        for (int k = 0; k < 4; k++) begin
            resolve(3'b001, 32'd1, 32'd2, 32'h20, 32'h400, 1'b0, 1'b1);
        end
        expect_res("bne_sat", 1'b1, 1'b0, 32'h400, 32'd8, 32'd2);
        expect_pred("sat_pred", 32'h20, 1'b1);
        resolve(3'b001, 32'd7, 32'd7, 32'h20, 32'h400, 1'b0, 1'b1);
        expect_res("bne_nt", 1'b0, 1'b1, 32'h24, 32'd9, 32'd3);
        expect_pred("ctr2_pred", 32'h20, 1'b1);
        expect_pred("alias_pred", 32'hA0, 1'b1);
        resolve(3'b001, 32'd7, 32'd7, 32'hA0, 32'h400, 1'b0, 1'b1);
        expect_res("alias_nt", 1'b0, 1'b1, 32'hA4, 32'd10, 32'd4);
        expect_pred("ctr1_pred", 32'h20, 1'b0);

        resolve(3'b001, 32'd3, 32'd3, 32'h80, 32'h500, 1'b1, 1'b1);
        expect_res("c_ft", 1'b0, 1'b1, 32'h82, 32'd11, 32'd5);
        resolve(3'b001, 32'd3, 32'd3, 32'h80, 32'h500, 1'b0, 1'b1);
        expect_res("ft4", 1'b0, 1'b1, 32'h84, 32'd12, 32'd6);
        resolve(3'b001, 32'd3, 32'd3, 32'hFFFF_FFFE, 32'h500, 1'b1, 1'b1);
        expect_res("wrap", 1'b0, 1'b1, 32'h0, 32'd13, 32'd7);
        @(posedge clk); #1;
        expect_res("idle", 1'b0, 1'b0, 32'h0, 32'd13, 32'd7);

        resolve(3'b010, 32'd9, 32'd1, 32'h40, 32'h600, 1'b0, 1'b1);
        check("ill.flag", {31'd0, illegal_funct3}, 32'd1);
        expect_res("ill", 1'b0, 1'b0, 32'h0, 32'd13, 32'd7);
        expect_pred("ill_pred", 32'h40, 1'b1);
        @(posedge clk); #1;
        check("ill.pulse", {31'd0, illegal_funct3}, 32'd0);

        res_is_branch = 1'b0; res_valid = 1'b1; res_funct3 = 3'b000;
        res_rs1 = 32'd1; res_rs2 = 32'd1; res_pc = 32'h40; res_pred_taken = 1'b0;
        @(posedge clk); #1;
        res_valid = 1'b0;
        expect_res("nonbr", 1'b0, 1'b0, 32'h0, 32'd13, 32'd7);

        rst = 1'b1;
        resolve(3'b000, 32'd4, 32'd4, 32'h40, 32'h700, 1'b0, 1'b0);
        rst = 1'b0;
        expect_res("rst_ev", 1'b0, 1'b0, 32'h0, 32'd0, 32'd0);
        check("rst_ev.illegal", {31'd0, illegal_funct3}, 32'd0);
        expect_pred("rst_pred40", 32'h40, 1'b0);
        expect_pred("rst_pred7e", 32'h7E, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
